// File: rtl/fse_filter.sv
// Complex fractionally-spaced equalizer datapath: T/2 delay line, one complex
// FIR evaluation per sample pair, products and saturated sums pipelined.
module fse_filter #(
  parameter int NUM_TAPS = 9,
  parameter int NBT_IN   = 8,
  parameter int NBF_IN   = 7,
  parameter int NBT_TAPS = 10,
  parameter int NBF_TAPS = 7,
  parameter int NBT_OUT  = 8,
  parameter int NBF_OUT  = 7
) (
  input  logic                              clk,
  input  logic                              i_reset,
  input  logic                              i_en_rx,
  input  logic                              i_valid,
  input  logic signed [NBT_IN-1:0]          i_data_I,
  input  logic signed [NBT_IN-1:0]          i_data_Q,
  input  logic        [NUM_TAPS*NBT_TAPS-1:0] i_taps_I,
  input  logic        [NUM_TAPS*NBT_TAPS-1:0] i_taps_Q,
  output logic signed [NBT_OUT-1:0]         o_data_I,
  output logic signed [NBT_OUT-1:0]         o_data_Q,
  output logic                              o_valid
);

  localparam int MUL_W  = NBT_IN + NBT_TAPS;
  localparam int PROD_W = MUL_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(NUM_TAPS);
  localparam int DROP   = NBF_TAPS + NBF_IN - NBF_OUT;

  // Floor away DROP fraction bits, then clamp the integer part to NBT_OUT.
  function automatic logic signed [NBT_OUT-1:0] sat_trunc(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0]     t;
    logic [SUM_W-NBT_OUT:0]      hi;
    t  = s >>> DROP;
    hi = t[SUM_W-1:NBT_OUT-1];
    if ((&hi) || !(|hi))
      sat_trunc = t[NBT_OUT-1:0];
    else if (s[SUM_W-1])
      sat_trunc = {1'b1, {(NBT_OUT-1){1'b0}}};
    else
      sat_trunc = {1'b0, {(NBT_OUT-1){1'b1}}};
  endfunction

  logic clr, accept, phase, r_fire, vld_p1;
  logic signed [NBT_IN-1:0] xi [NUM_TAPS];
  logic signed [NBT_IN-1:0] xq [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_i_c [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q_c [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_i_p1 [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q_p1 [NUM_TAPS];
  logic signed [SUM_W-1:0]  sum_i, sum_q;

  assign clr    = i_reset | ~i_en_rx;
  assign accept = i_valid & i_en_rx;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_mul
    logic signed [NBT_TAPS-1:0] wi, wq;
    logic signed [MUL_W-1:0]    ii, qq, iq, qi;
    assign wi = i_taps_I[k*NBT_TAPS +: NBT_TAPS];
    assign wq = i_taps_Q[k*NBT_TAPS +: NBT_TAPS];
    assign ii = wi * xi[k];
    assign qq = wq * xq[k];
    assign iq = wi * xq[k];
    assign qi = wq * xi[k];
    assign prod_i_c[k] = {ii[MUL_W-1], ii} - {qq[MUL_W-1], qq};
    assign prod_q_c[k] = {iq[MUL_W-1], iq} + {qi[MUL_W-1], qi};
  end

  // Stage 0: delay line, pair phase and fire flag
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        xi[k] <= '0;
        xq[k] <= '0;
      end
      phase  <= 1'b0;
      r_fire <= 1'b0;
    end else begin
      r_fire <= accept & phase;
      if (accept) begin
        phase <= ~phase;
        xi[0] <= i_data_I;
        xq[0] <= i_data_Q;
        for (int k = 1; k < NUM_TAPS; k++) begin
          xi[k] <= xi[k-1];
          xq[k] <= xq[k-1];
        end
      end
    end
  end

  // Stage 1: complex products, taps sampled only here
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod_i_p1[k] <= '0;
        prod_q_p1[k] <= '0;
      end
    end else begin
      vld_p1 <= r_fire;
      if (r_fire) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          prod_i_p1[k] <= prod_i_c[k];
          prod_q_p1[k] <= prod_q_c[k];
        end
      end
    end
  end

  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum_i = sum_i + {{(SUM_W-PROD_W){prod_i_p1[k][PROD_W-1]}}, prod_i_p1[k]};
      sum_q = sum_q + {{(SUM_W-PROD_W){prod_q_p1[k][PROD_W-1]}}, prod_q_p1[k]};
    end
  end

  // Stage 2: quantized output, held between strobes
  always_ff @(posedge clk) begin
    if (clr) begin
      o_valid  <= 1'b0;
      o_data_I <= '0;
      o_data_Q <= '0;
    end else begin
      o_valid <= vld_p1;
      if (vld_p1) begin
        o_data_I <= sat_trunc(sum_i);
        o_data_Q <= sat_trunc(sum_q);
      end
    end
  end

endmodule

// File: tb/tb_fse_filter.sv
// Directed bench for fse_filter: impulse, rotation, saturation, throughput,
// truncation and mid-pipeline disable, each against hand-computed values.
module tb_fse_filter;
  localparam int NT = 9;
  localparam int TW = 10;

  logic clk = 1'b0;
  logic rst, en, valid;
  logic [7:0] din_i, din_q;
  logic [NT*TW-1:0] taps_i, taps_q;
  logic signed [7:0] dout_i, dout_q;
  logic dout_vld;

  fse_filter dut (
    .clk(clk), .i_reset(rst), .i_en_rx(en), .i_valid(valid),
    .i_data_I(din_i), .i_data_Q(din_q),
    .i_taps_I(taps_i), .i_taps_Q(taps_q),
    .o_data_I(dout_i), .o_data_Q(dout_q), .o_valid(dout_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [7:0] di; logic [7:0] dq; } pulse_t;
  pulse_t pq[$];
  always @(negedge clk) if (dout_vld) pq.push_back('{cyc, dout_i, dout_q});

  int nchk = 0, nerr = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] di, input logic [7:0] dq);
    valid = v; din_i = di; din_q = dq;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1;
    idle(1);
    rst = 1'b0;
    pq.delete();
  endtask

  task automatic set_center(input logic [9:0] wi, input logic [9:0] wq, input int k);
    taps_i = '0; taps_q = '0;
    taps_i[k*TW +: TW] = wi;
    taps_q[k*TW +: TW] = wq;
  endtask

  int edge_n1, bad, nz;

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; din_i = '0; din_q = '0;
    taps_i = '0; taps_q = '0;
    idle(2);
    check("rst_valid", 32'(dout_vld), 0);
    check("rst_data_i", 32'(dout_i), 0);
    check("rst_data_q", 32'(dout_q), 0);
    rst = 1'b0;

    // Impulse at sample 1 lands in x[4] for the fire at sample 5 (pulse 2)
    do_reset();
    set_center(10'h080, 10'h000, 4);
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, (n == 1) ? 8'h40 : 8'h00, 8'h00);
      if (n == 1) edge_n1 = cyc;
    end
    idle(4);
    check("imp_count", 32'(pq.size()), 10);
    if (pq.size() == 10) begin
      // E0 is edge_n1; o_valid is visible after the second edge that follows
      check("imp_latency", 32'(pq[0].c - edge_n1), 2);
      bad = 0; nz = 0;
      for (int p = 1; p < 10; p++) if (pq[p].c - pq[p-1].c != 2) bad++;
      for (int p = 0; p < 10; p++) if (p != 2 && (pq[p].di != 0 || pq[p].dq != 0)) nz++;
      check("imp_gap2", 32'(bad), 0);
      check("imp_others_zero", 32'(nz), 0);
      check("imp_peak_i", 32'(pq[2].di), 32'h40);
      check("imp_peak_q", 32'(pq[2].dq), 32'h00);
    end

    // Strobes spaced 3 cycles apart
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 8'h00, 8'h00);
      idle(2);
    end
    idle(3);
    check("spaced_count", 32'(pq.size()), 2);
    if (pq.size() == 2) check("spaced_gap", 32'(pq[1].c - pq[0].c), 6);

    // Rotation by j
    do_reset();
    set_center(10'h000, 10'h080, 4);
    for (int n = 0; n < 10; n++) drive(1'b1, 8'h40, 8'h00);
    idle(4);
    check("rot_count", 32'(pq.size()), 5);
    if (pq.size() == 5) begin
      check("rot_i", 32'(pq[4].di), 32'h00);
      check("rot_q", 32'(pq[4].dq), 32'h40);
    end

    // Saturation both directions
    do_reset();
    taps_i = {NT{10'h1FF}}; taps_q = '0;
    for (int n = 0; n < 10; n++) drive(1'b1, 8'h7F, 8'h00);
    idle(4);
    if (pq.size() == 5) check("sat_pos_i", 32'(pq[4].di), 32'h7F);
    else check("sat_pos_count", 32'(pq.size()), 5);
    do_reset();
    for (int n = 0; n < 10; n++) drive(1'b1, 8'h80, 8'h00);
    idle(4);
    if (pq.size() == 5) begin
      check("sat_neg_i", 32'(pq[4].di), 32'h80);
      check("sat_neg_q", 32'(pq[4].dq), 32'h00);
    end else check("sat_neg_count", 32'(pq.size()), 5);

    // Truncation: 129*127=16383 -> 127; 127*1 -> 0; 127*(-1) -> floor -1
    do_reset();
    set_center(10'h081, 10'h000, 0);
    drive(1'b1, 8'h00, 8'h00); drive(1'b1, 8'h7F, 8'h00);
    idle(4);
    set_center(10'h07F, 10'h000, 0);
    drive(1'b1, 8'h00, 8'h00); drive(1'b1, 8'h01, 8'h00);
    idle(4);
    drive(1'b1, 8'h00, 8'h00); drive(1'b1, 8'hFF, 8'h00);
    idle(4);
    check("trunc_count", 32'(pq.size()), 3);
    if (pq.size() == 3) begin
      check("trunc_up", 32'(pq[0].di), 32'h7F);
      check("trunc_small", 32'(pq[1].di), 32'h00);
      check("trunc_floor_neg", 32'(pq[2].di), 32'hFF);
    end

    // Disable at E1 of a pending result
    do_reset();
    set_center(10'h080, 10'h000, 0);
    for (int n = 0; n < 4; n++) drive(1'b1, 8'h40, 8'h00);
    idle(4);
    check("pre_dis_i", 32'(dout_i), 32'h40);
    pq.delete();
    drive(1'b1, 8'h30, 8'h00); drive(1'b1, 8'h30, 8'h00);
    en = 1'b0;
    drive(1'b1, 8'h55, 8'h00);
    en = 1'b1;
    idle(5);
    check("dis_no_valid", 32'(pq.size()), 0);
    check("dis_data_i", 32'(dout_i), 32'h00);
    drive(1'b1, 8'h10, 8'h00);
    idle(4);
    check("reen_first_nofire", 32'(pq.size()), 0);
    drive(1'b1, 8'h20, 8'h00);
    idle(4);
    check("reen_pair_count", 32'(pq.size()), 1);
    if (pq.size() == 1) check("reen_pair_i", 32'(pq[0].di), 32'h20);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
